data_cache: RTL and testbench

DATA_CACHE -- requirements
Module: data_cache

---
 rtl/data_cache_pkg.sv | 20 ++
 rtl/data_cache_line_store.sv | 56 +++++
 rtl/data_cache.sv | 161 ++++++++++++++++
 tb/tb_data_cache.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_cache_pkg.sv
// Shared definitions for the data cache: word size, address field widths,
// controller state encoding and a saturating-counter helper.
package data_cache_pkg;

  localparam int WORD_SIZE = 16;
  localparam int OFFSET_W  = 2;
  localparam int INDEX_W   = 2;
  localparam int TAG_W     = WORD_SIZE - INDEX_W - OFFSET_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } cache_state_e;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/data_cache_line_store.sv
// cache_line_store: tag / valid / data arrays for the direct-mapped cache.
// Reads are combinational on index/offset; writes are synchronous.
// Ports:
//   clk, reset_n          clock, synchronous active-low reset (clears valid bits only)
//   index, offset         line select and word select
//   rd_valid, rd_tag      valid bit and stored tag of the selected line
//   rd_word               selected word of the selected line
//   fill_en/fill_tag/fill_line  whole-line refill, sets valid
//   word_en/word_data     single-word update of the selected line
module cache_line_store
  import data_cache_pkg::*;
#(
  parameter int LINES          = 4,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [INDEX_W-1:0]                  index,
  input  logic [OFFSET_W-1:0]                 offset,
  output logic                                rd_valid,
  output logic [TAG_W-1:0]                    rd_tag,
  output logic [WORD_SIZE-1:0]                rd_word,
  input  logic                                fill_en,
  input  logic [TAG_W-1:0]                    fill_tag,
  input  logic [WORDS_PER_LINE*WORD_SIZE-1:0] fill_line,
  input  logic                                word_en,
  input  logic [WORD_SIZE-1:0]                word_data
);

  logic [LINES-1:0]                    valid_q;
  logic [TAG_W-1:0]                    tag_q  [LINES];
  logic [WORDS_PER_LINE*WORD_SIZE-1:0] data_q [LINES];

  assign rd_valid = valid_q[index];
  assign rd_tag   = tag_q[index];
  assign rd_word  = data_q[index][int'(offset)*WORD_SIZE +: WORD_SIZE];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[index] <= 1'b1;
    end
  end

  // Tag and data contents are left as-is by reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[index]  <= fill_tag;
      data_q[index] <= fill_line;
    end else if (word_en) begin
      data_q[index][int'(offset)*WORD_SIZE +: WORD_SIZE] <= word_data;
    end
  end

endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate data cache
// for the MEM stage. Read hits complete in the same cycle; misses refill a
// whole line from backing memory; every write goes to memory.
// Ports:
//   clk, reset_n                      clock, synchronous active-low reset
//   cpu_read, cpu_write               CPU request, held until cpu_ready
//   cpu_address, cpu_wdata            word address and store data
//   cpu_rdata, cpu_ready              load data, completion / stall
//   mem_read_req, mem_write_req       backing-memory requests
//   mem_address, mem_wdata            line base (read) or word address (write), store data
//   mem_rdata, mem_ack                refill line (word 0 in [15:0]), one-cycle completion
//   hit_count, access_count           saturating statistics
//
// state | meaning
// IDLE  | serve read hits, accept a new miss or write
// FILL  | line refill outstanding, CPU stalled
// WRITE | write-through outstanding, CPU stalled until ack
module data_cache
  import data_cache_pkg::*;
#(
  parameter int LINES          = 4,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cpu_read,
  input  logic                   cpu_write,
  input  logic [WORD_SIZE-1:0]   cpu_address,
  input  logic [WORD_SIZE-1:0]   cpu_wdata,
  output logic [WORD_SIZE-1:0]   cpu_rdata,
  output logic                   cpu_ready,
  output logic                   mem_read_req,
  output logic                   mem_write_req,
  output logic [WORD_SIZE-1:0]   mem_address,
  output logic [WORD_SIZE-1:0]   mem_wdata,
  input  logic [4*WORD_SIZE-1:0] mem_rdata,
  input  logic                   mem_ack,
  output logic [15:0]            hit_count,
  output logic [15:0]            access_count
);

  cache_state_e state_q, state_next;

  logic [TAG_W-1:0]    addr_tag;
  logic [INDEX_W-1:0]  addr_index;
  logic [OFFSET_W-1:0] addr_offset;

  logic                 line_valid;
  logic [TAG_W-1:0]     line_tag;
  logic [WORD_SIZE-1:0] line_word;
  logic                 hit;

  logic fill_en, word_en;
  logic fill_seen_q;
  logic access_done, hit_event;

  assign addr_tag    = cpu_address[WORD_SIZE-1 -: TAG_W];
  assign addr_index  = cpu_address[OFFSET_W +: INDEX_W];
  assign addr_offset = cpu_address[OFFSET_W-1:0];

  assign hit = line_valid && (line_tag == addr_tag);

  cache_line_store #(
    .LINES          (LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_store (
    .clk       (clk),
    .reset_n   (reset_n),
    .index     (addr_index),
    .offset    (addr_offset),
    .rd_valid  (line_valid),
    .rd_tag    (line_tag),
    .rd_word   (line_word),
    .fill_en   (fill_en && reset_n),
    .fill_tag  (addr_tag),
    .fill_line (mem_rdata),
    .word_en   (word_en && reset_n),
    .word_data (cpu_wdata)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  always_comb begin
    state_next    = state_q;
    cpu_ready     = 1'b0;
    cpu_rdata     = '0;
    mem_read_req  = 1'b0;
    mem_write_req = 1'b0;
    mem_address   = '0;
    mem_wdata     = '0;
    fill_en       = 1'b0;
    word_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_write) begin
          state_next = WRITE;
        end else if (cpu_read) begin
          if (hit) begin
            cpu_ready = 1'b1;
            cpu_rdata = line_word;
          end else begin
            state_next = FILL;
          end
        end else begin
          cpu_ready = 1'b1;
        end
      end
      FILL: begin
        mem_read_req = 1'b1;
        mem_address  = {addr_tag, addr_index, {OFFSET_W{1'b0}}};
        if (mem_ack) begin
          fill_en    = 1'b1;
          state_next = IDLE;
        end
      end
      WRITE: begin
        mem_write_req = 1'b1;
        mem_address   = cpu_address;
        mem_wdata     = cpu_wdata;
        if (mem_ack) begin
          cpu_ready  = 1'b1;
          word_en    = hit;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Remembers that the read now being retried in IDLE went through a refill,
  // so its completion is counted as an access but not as a hit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fill_seen_q <= 1'b0;
    end else if (state_q == IDLE) begin
      fill_seen_q <= (state_next == FILL);
    end
  end

  assign access_done = cpu_ready && (cpu_read || cpu_write);
  assign hit_event   = access_done &&
                       (((state_q == IDLE) && !fill_seen_q) ||
                        ((state_q == WRITE) && hit));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      access_count <= '0;
      hit_count    <= '0;
    end else begin
      if (access_done) access_count <= sat_inc(access_count);
      if (hit_event)   hit_count    <= sat_inc(hit_count);
    end
  end

endmodule

// File: tb/tb_data_cache.sv
module tb_data_cache;
  import data_cache_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_read, cpu_write;
  logic [15:0] cpu_address, cpu_wdata, cpu_rdata;
  logic        cpu_ready;
  logic        mem_read_req, mem_write_req;
  logic [15:0] mem_address, mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] hit_count, access_count;

  always #5 clk = ~clk;

  data_cache #(.LINES(4), .WORDS_PER_LINE(4)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cpu_read      (cpu_read),
    .cpu_write     (cpu_write),
    .cpu_address   (cpu_address),
    .cpu_wdata     (cpu_wdata),
    .cpu_rdata     (cpu_rdata),
    .cpu_ready     (cpu_ready),
    .mem_read_req  (mem_read_req),
    .mem_write_req (mem_write_req),
    .mem_address   (mem_address),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ack       (mem_ack),
    .hit_count     (hit_count),
    .access_count  (access_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: cache contents by line, backing memory by word address.
  bit          m_valid [4];
  logic [11:0] m_tag   [4];
  logic [15:0] m_data  [4][4];
  logic [15:0] m_hits, m_acc;
  logic [15:0] bmem [int];

  function automatic logic [15:0] inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [15:0] bmem_rd(input int a);
    if (bmem.exists(a)) return bmem[a];
    return 16'(a * 40503) ^ 16'h5A5A;
  endfunction

  function automatic bit m_hit(input logic [15:0] a);
    return m_valid[a[3:2]] && (m_tag[a[3:2]] == a[15:4]);
  endfunction

  task automatic check_idle();
    @(negedge clk);
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    mem_ack   = ($urandom_range(0, 3) == 0);
    mem_rdata = {$urandom, $urandom};
    #1;
    check_val("idle_ready", cpu_ready, 1'b1);
    check_val("idle_reqs", {mem_write_req, mem_read_req}, 2'b00);
    check_val("idle_rdata", cpu_rdata, 16'h0);
    check_val("access_count", access_count, m_acc);
    check_val("hit_count", hit_count, m_hits);
    @(posedge clk);
  endtask

  task automatic do_read(input logic [15:0] a, input int delay);
    bit          h;
    logic [15:0] base;
    @(negedge clk);
    mem_ack     = 1'b0;
    cpu_read    = 1'b1;
    cpu_write   = 1'b0;
    cpu_address = a;
    cpu_wdata   = 16'($urandom);
    h = m_hit(a);
    #1;
    if (h) begin
      check_val("hit_ready", cpu_ready, 1'b1);
      check_val("hit_rdata", cpu_rdata, m_data[a[3:2]][a[1:0]]);
      check_val("hit_noreq", {mem_write_req, mem_read_req}, 2'b00);
      @(posedge clk);
      m_acc  = inc16(m_acc);
      m_hits = inc16(m_hits);
    end else begin
      check_val("miss_stall", cpu_ready, 1'b0);
      @(posedge clk);
      base = {a[15:2], 2'b00};
      for (int i = 0; i < delay; i++) begin
        @(negedge clk); #1;
        check_val("fill_req", {mem_write_req, mem_read_req}, 2'b01);
        check_val("fill_addr", mem_address, base);
        check_val("fill_stall", cpu_ready, 1'b0);
        @(posedge clk);
      end
      @(negedge clk);
      mem_ack = 1'b1;
      for (int w = 0; w < 4; w++) mem_rdata[w*16 +: 16] = bmem_rd(int'(base) + w);
      #1;
      check_val("fill_ack_req", {mem_write_req, mem_read_req}, 2'b01);
      check_val("fill_ack_stall", cpu_ready, 1'b0);
      @(posedge clk);
      m_valid[a[3:2]] = 1'b1;
      m_tag[a[3:2]]   = a[15:4];
      for (int w = 0; w < 4; w++) m_data[a[3:2]][w] = bmem_rd(int'(base) + w);
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = {$urandom, $urandom};
      #1;
      check_val("retry_ready", cpu_ready, 1'b1);
      check_val("retry_rdata", cpu_rdata, m_data[a[3:2]][a[1:0]]);
      check_val("retry_noreq", {mem_write_req, mem_read_req}, 2'b00);
      @(posedge clk);
      m_acc = inc16(m_acc);
    end
    check_idle();
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d, input int delay, input bit both);
    bit h;
    @(negedge clk);
    mem_ack     = 1'b0;
    cpu_write   = 1'b1;
    cpu_read    = both;
    cpu_address = a;
    cpu_wdata   = d;
    #1;
    check_val("wr_stall", cpu_ready, 1'b0);
    check_val("wr_idle_noreq", {mem_write_req, mem_read_req}, 2'b00);
    check_val("wr_idle_rdata", cpu_rdata, 16'h0);
    @(posedge clk);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk); #1;
      check_val("wr_req", {mem_write_req, mem_read_req}, 2'b10);
      check_val("wr_addr", mem_address, a);
      check_val("wr_data", mem_wdata, d);
      check_val("wr_wait_stall", cpu_ready, 1'b0);
      @(posedge clk);
    end
    @(negedge clk);
    mem_ack = 1'b1;
    #1;
    check_val("wr_ack_req", {mem_write_req, mem_read_req}, 2'b10);
    check_val("wr_ack_addr", mem_address, a);
    check_val("wr_ack_ready", cpu_ready, 1'b1);
    h = m_hit(a);
    @(posedge clk);
    bmem[int'(a)] = d;
    if (h) m_data[a[3:2]][a[1:0]] = d;
    m_acc = inc16(m_acc);
    if (h) m_hits = inc16(m_hits);
    check_idle();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    mem_ack   = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
    m_acc  = '0;
    m_hits = '0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_val("rst_reqs", {mem_write_req, mem_read_req}, 2'b00);
    check_val("rst_rdata", cpu_rdata, 16'h0);
    check_val("rst_ready", cpu_ready, 1'b1);
    check_val("rst_access", access_count, 16'h0);
    check_val("rst_hits", hit_count, 16'h0);
    @(posedge clk);
  endtask

  logic [11:0] tags [4];
  logic [15:0] ra;

  initial begin
    reset_n     = 1'b0;
    cpu_read    = 1'b0;
    cpu_write   = 1'b0;
    cpu_address = '0;
    cpu_wdata   = '0;
    mem_rdata   = '0;
    mem_ack     = 1'b0;
    m_acc       = '0;
    m_hits      = '0;
    for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
    tags[0] = 12'h001; tags[1] = 12'h002; tags[2] = 12'h010; tags[3] = 12'h3A7;
    repeat (2) @(posedge clk);
    apply_reset();

    bmem[16'h0010] = 16'h000A;
    bmem[16'h0011] = 16'h000B;
    bmem[16'h0012] = 16'h000C;
    bmem[16'h0013] = 16'h000D;

    do_read(16'h0012, 0);               // cold miss, line fill
    do_read(16'h0013, 0);               // same-cycle hit
    do_write(16'h0011, 16'h5555, 1, 0); // write hit updates cached word
    do_read(16'h0011, 0);
    do_write(16'h0100, 16'h1234, 2, 0); // write miss, no allocate
    do_read(16'h0100, 0);               // then misses
    do_read(16'h0022, 0);               // conflicting tag, index 0
    do_read(16'h0012, 5);               // eviction forces refill, slow ack
    do_write(16'h0022, 16'hBEEF, 0, 1); // read+write together: write wins

    // Reset in the middle of a refill.
    @(negedge clk);
    mem_ack     = 1'b0;
    cpu_read    = 1'b1;
    cpu_address = 16'h0034;
    @(posedge clk);
    @(negedge clk); #1;
    check_val("midfill_req", {mem_write_req, mem_read_req}, 2'b01);
    @(posedge clk);
    apply_reset();
    do_read(16'h0034, 1);
    do_read(16'h0012, 0);

    for (int n = 0; n < 80; n++) begin
      ra = {tags[$urandom_range(0, 3)], 4'($urandom)};
      if ($urandom_range(0, 9) < 6) do_read(ra, $urandom_range(0, 3));
      else do_write(ra, 16'($urandom), $urandom_range(0, 3), $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
